// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin multiplexer.
package mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Increment modulo n; n need not be a power of two.
   function automatic int wrap_inc(input int v, input int n);
      if (v + 1 >= n) return 0;
      return v + 1;
   endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Producer-side and consumer-side handshake bundle of the multiplexer.
// A word moves on a rising edge when its valid and ready are both high; valid must not depend on ready.
interface mux_rr_arb_if #(
   parameter int NCH = 4,
   parameter int W   = 8
);
   localparam int CW = $clog2(NCH);

   logic [NCH-1:0]   i_valid;
   logic [NCH*W-1:0] i_data;
   logic [NCH-1:0]   i_ready;
   logic [CW-1:0]    s;
   logic             s_en;
   logic             o_valid;
   logic [W-1:0]     o_data;
   logic [CW-1:0]    o_ch;
   logic             o_ready;
   logic             dbg_state;

   modport slave (
      input  i_valid, i_data, s, s_en, o_ready,
      output i_ready, o_valid, o_data, o_ch, dbg_state
   );

   modport master (
      output i_valid, i_data, s, s_en, o_ready,
      input  i_ready, o_valid, o_data, o_ch, dbg_state
   );

endinterface

// File: rtl/rr_arb.sv
// Round-robin / fixed-priority arbiter: one-hot grant plus encoded index.
// The search pointer moves past the winner only when the grant is actually taken.
module rr_arb
   import mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int MODE = MODE_RR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCH-1:0]           elig_i,
   input  logic                     load_i,
   output logic [NCH-1:0]           gnt_o,
   output logic [$clog2(NCH)-1:0]   idx_o,
   output logic                     any_o
);

   localparam int CW = $clog2(NCH);

   logic [CW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] base;
   logic [CW:0]   sum;
   logic [CW-1:0] cand;
   logic          found;

   // Fixed priority is simply a round-robin search that always starts at 0.
   always_comb begin
      base  = (MODE == MODE_FIXED) ? '0 : ptr_q;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NCH; i++) begin
         sum = {1'b0, base} + (CW+1)'(i);
         if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
         cand = sum[CW-1:0];
         if (!found && elig_i[cand]) begin
            found = 1'b1;
            idx_o = cand;
         end
      end
   end

   assign any_o = found;
   assign gnt_o = found ? (NCH'(1) << idx_o) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (load_i && (MODE == MODE_RR)) ptr_d = CW'(wrap_inc(int'(idx_o), NCH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel W-bit arbitrated multiplexer with a single registered output stage.
// Accepts one word per clock when the consumer keeps o_ready high.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int W    = 8,
   parameter int MODE = MODE_RR
) (
   input  logic          clk,
   input  logic          rst,
   mux_rr_arb_if.slave   bus
);

   localparam int CW = $clog2(NCH);

   logic [NCH-1:0] elig;
   logic [NCH-1:0] gnt;
   logic [CW-1:0]  gnt_idx;
   logic           any_elig;
   logic           load_en;
   logic           xfer;
   logic [W-1:0]   sel_data;

   logic [0:0]     state_q, state_d;
   logic [W-1:0]   data_q, data_d;
   logic [CW-1:0]  ch_q, ch_d;

   // An out-of-range forced select matches no channel, so nothing is eligible.
   always_comb begin
      elig = '0;
      for (int k = 0; k < NCH; k++) begin
         elig[k] = bus.i_valid[k] & (!bus.s_en | (bus.s == CW'(k)));
      end
   end

   rr_arb #(
      .NCH  (NCH),
      .MODE (MODE)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .elig_i (elig),
      .load_i (xfer),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx),
      .any_o  (any_elig)
   );

   assign load_en     = (state_q == ST_EMPTY) | bus.o_ready;
   assign xfer        = load_en & any_elig & !rst;
   assign bus.i_ready = xfer ? gnt : '0;

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt[k]) sel_data = sel_data | bus.i_data[k*W +: W];
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      if (xfer) begin
         state_d = ST_FULL;
         data_d  = sel_data;
         ch_d    = gnt_idx;
      end else if ((state_q == ST_FULL) && bus.o_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
      end
   end

   assign bus.o_valid   = (state_q == ST_FULL);
   assign bus.o_data    = data_q;
   assign bus.o_ch      = ch_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: a round-robin and a fixed-priority instance share stimulus.
module tb_mux_rr_arb;
   import mux_pkg::*;

   localparam int NCH = 4;
   localparam int W   = 8;
   localparam int CW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NCH-1:0]   i_valid = '0;
   logic [NCH*W-1:0] i_data  = '0;
   logic [CW-1:0]    s       = '0;
   logic             s_en    = 1'b0;
   logic             o_ready = 1'b0;
   logic             fx_en   = 1'b0;

   mux_rr_arb_if #(.NCH(NCH), .W(W)) bus_rr ();
   mux_rr_arb_if #(.NCH(NCH), .W(W)) bus_fx ();

   assign bus_rr.i_valid = i_valid & {NCH{!fx_en}};
   assign bus_rr.i_data  = i_data;
   assign bus_rr.s       = s;
   assign bus_rr.s_en    = s_en;
   assign bus_rr.o_ready = o_ready;
   assign bus_fx.i_valid = i_valid & {NCH{fx_en}};
   assign bus_fx.i_data  = i_data;
   assign bus_fx.s       = s;
   assign bus_fx.s_en    = s_en;
   assign bus_fx.o_ready = o_ready;

   mux_rr_arb #(.NCH(NCH), .W(W), .MODE(MODE_RR))    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
   mux_rr_arb #(.NCH(NCH), .W(W), .MODE(MODE_FIXED)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));

   int checks = 0;
   int errors = 0;
   logic [CW+W-1:0] exp_rr_q[$];
   logic [CW+W-1:0] exp_fx_q[$];
   logic [CW+W-1:0] e_rr, e_fx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_rr(input logic [CW-1:0] ch, input logic [W-1:0] d);
      exp_rr_q.push_back({ch, d});
   endtask

   task automatic push_fx(input logic [CW-1:0] ch, input logic [W-1:0] d);
      exp_fx_q.push_back({ch, d});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitors: a word is consumed at the next rising edge whenever valid and ready are high here.
   always @(negedge clk) begin
      if (!rst && bus_rr.o_valid && o_ready) begin
         if (exp_rr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rr_unexpected: got ch%0d data 0x%0h expected none", bus_rr.o_ch, bus_rr.o_data);
         end else begin
            e_rr = exp_rr_q.pop_front();
            check("rr_ch",   32'(bus_rr.o_ch),   32'(e_rr[CW+W-1:W]));
            check("rr_data", 32'(bus_rr.o_data), 32'(e_rr[W-1:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus_fx.o_valid && o_ready) begin
         if (exp_fx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fx_unexpected: got ch%0d data 0x%0h expected none", bus_fx.o_ch, bus_fx.o_data);
         end else begin
            e_fx = exp_fx_q.pop_front();
            check("fx_ch",   32'(bus_fx.o_ch),   32'(e_fx[CW+W-1:W]));
            check("fx_data", 32'(bus_fx.o_data), 32'(e_fx[W-1:0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all inputs active
      i_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      i_valid = 4'b1111;
      o_ready = 1'b1;
      rst     = 1'b1;
      #12;
      check("rst_o_valid",  32'(bus_rr.o_valid),   32'd0);
      check("rst_o_data",   32'(bus_rr.o_data),    32'd0);
      check("rst_o_ch",     32'(bus_rr.o_ch),      32'd0);
      check("rst_i_ready",  32'(bus_rr.i_ready),   32'd0);
      check("rst_state",    32'(bus_rr.dbg_state), 32'd0);
      check("rst_fx_valid", 32'(bus_fx.o_valid),   32'd0);

      // Round-robin fairness
      push_rr(2'd0, 8'h11);
      push_rr(2'd1, 8'h22);
      push_rr(2'd2, 8'h33);
      push_rr(2'd3, 8'h44);
      push_rr(2'd0, 8'h11);
      rst = 1'b0;
      #1;
      check("rr_first_ready", 32'(bus_rr.i_ready), 32'b0001);
      repeat (5) @(posedge clk);
      #1;
      i_valid = '0;
      idle(3);

      // Fixed priority
      fx_en   = 1'b1;
      i_valid = 4'b1010;
      for (int i = 0; i < 4; i++) push_fx(2'd1, 8'h22);
      #1;
      check("fx_ready", 32'(bus_fx.i_ready), 32'b0010);
      check("fx_rr_idle_ready", 32'(bus_rr.i_ready), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      i_valid = '0;
      idle(3);
      fx_en = 1'b0;

      // Back-pressure: ptr is 1, load ch1 then stall
      push_rr(2'd1, 8'h22);
      push_rr(2'd2, 8'h33);
      i_valid = 4'b1111;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_valid", 32'(bus_rr.o_valid),   32'd1);
         check("stall_data",  32'(bus_rr.o_data),    32'h22);
         check("stall_ch",    32'(bus_rr.o_ch),      32'd1);
         check("stall_ready", 32'(bus_rr.i_ready),   32'd0);
         check("stall_state", 32'(bus_rr.dbg_state), 32'd1);
      end
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      i_valid = '0;
      idle(3);

      // Forced select to ch2, then round-robin resumes from ch3
      s       = 2'd2;
      s_en    = 1'b1;
      i_valid = 4'b1111;
      for (int i = 0; i < 3; i++) push_rr(2'd2, 8'h33);
      push_rr(2'd3, 8'h44);
      push_rr(2'd0, 8'h11);
      #1;
      check("force_ready", 32'(bus_rr.i_ready), 32'b0100);
      repeat (3) @(posedge clk);
      #1;
      s_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_valid = '0;
      idle(3);

      // Forced select onto an idle channel grants nothing
      s       = 2'd1;
      s_en    = 1'b1;
      i_valid = 4'b1101;
      #1;
      check("force_idle_ready", 32'(bus_rr.i_ready), 32'd0);
      idle(2);
      check("force_idle_valid", 32'(bus_rr.o_valid), 32'd0);
      s_en    = 1'b0;
      i_valid = '0;
      idle(1);

      // Asynchronous reset while a word is held (ptr is 1 here)
      i_valid = 4'b1111;
      o_ready = 1'b0;
      @(posedge clk);
      #1;
      check("mid_loaded_valid", 32'(bus_rr.o_valid), 32'd1);
      check("mid_loaded_data",  32'(bus_rr.o_data),  32'h22);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus_rr.o_valid), 32'd0);
      check("mid_rst_data",  32'(bus_rr.o_data),  32'd0);
      check("mid_rst_ch",    32'(bus_rr.o_ch),    32'd0);
      check("mid_rst_ready", 32'(bus_rr.i_ready), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      o_ready = 1'b1;
      push_rr(2'd0, 8'h11);
      #1;
      check("post_rst_ready", 32'(bus_rr.i_ready), 32'b0001);
      @(posedge clk);
      #1;
      i_valid = '0;
      idle(3);

      for (int i = 0; i < 50 && (exp_rr_q.size() != 0 || exp_fx_q.size() != 0); i++) idle(1);
      check("rr_queue_empty", 32'(exp_rr_q.size()), 32'd0);
      check("fx_queue_empty", 32'(exp_fx_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
